// File: rtl/clock_enable_gen_if.sv
// Control/status bundle for clock_enable_gen: divisor programming, sync and per-channel outputs.
// Readback signals exist only when CLKDIV_READBACK_EN is defined.
interface clock_enable_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
);
    logic             sync;
    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_data;
    logic [N_CH-1:0]  en_out;
    logic [N_CH-1:0]  tog_out;
`ifdef CLKDIV_READBACK_EN
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data;

    modport master (output sync, div_wr, div_sel, div_data, rd_sel,
                    input  en_out, tog_out, rd_data);
    modport slave  (input  sync, div_wr, div_sel, div_data, rd_sel,
                    output en_out, tog_out, rd_data);
`else
    modport master (output sync, div_wr, div_sel, div_data,
                    input  en_out, tog_out);
    modport slave  (input  sync, div_wr, div_sel, div_data,
                    output en_out, tog_out);
`endif
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: one-cycle enable pulse and toggle per channel.
// Optional counter readback port is built when CLKDIV_READBACK_EN is defined.
module clock_enable_gen #(
    parameter int                    N_CH     = 4,
    parameter int                    CNT_W    = 32,
    parameter int                    SEL_W    = 4,
    parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {32'd50000000, 32'd100000, 32'd262144, 32'd4}
) (
    input  logic             clk,
    input  logic             clr,
    clock_enable_gen_if.slave bus
);
    logic [N_CH-1:0] w_en;
    logic [N_CH-1:0] w_tog;
`ifdef CLKDIV_READBACK_EN
    logic [CNT_W-1:0] w_cnt_pad [2**SEL_W];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_sdiv;
            logic [CNT_W-1:0] r_adiv;
            logic [CNT_W-1:0] r_cnt;
            logic             r_en;
            logic             r_tog;
            logic             w_wr_hit;
            logic             w_halted;
            logic             w_wrap;
            logic [CNT_W-1:0] w_new_div;

            // Out-of-range selects match no channel, so they are silently dropped.
            assign w_wr_hit  = bus.div_wr && (bus.div_sel == SEL_W'(gi));
            // A write coinciding with an adiv load is forwarded straight into adiv.
            assign w_new_div = w_wr_hit ? bus.div_data : r_sdiv;
            assign w_halted  = (r_adiv == '0);
            assign w_wrap    = !w_halted && (r_cnt == r_adiv - CNT_W'(1));

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_sdiv <= DIV_INIT[gi*CNT_W +: CNT_W];
                    r_adiv <= DIV_INIT[gi*CNT_W +: CNT_W];
                    r_cnt  <= '0;
                    r_en   <= 1'b0;
                    r_tog  <= 1'b0;
                end else begin
                    r_sdiv <= w_new_div;
                    if (bus.sync) begin
                        r_cnt  <= '0;
                        r_en   <= 1'b0;
                        r_tog  <= 1'b0;
                        r_adiv <= w_new_div;
                    end else if (w_halted) begin
                        r_cnt  <= '0;
                        r_en   <= 1'b0;
                        r_adiv <= w_new_div;
                    end else if (w_wrap) begin
                        r_cnt  <= '0;
                        r_en   <= 1'b1;
                        r_tog  <= ~r_tog;
                        r_adiv <= w_new_div;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_en   <= 1'b0;
                    end
                end
            end

            assign w_en[gi]  = r_en;
            assign w_tog[gi] = r_tog;
`ifdef CLKDIV_READBACK_EN
            assign w_cnt_pad[gi] = r_cnt;
`endif
        end

`ifdef CLKDIV_READBACK_EN
        // Pad the readback table to the full select range so rd_sel never indexes past it.
        for (gi = N_CH; gi < 2**SEL_W; gi++) begin : g_pad
            assign w_cnt_pad[gi] = '0;
        end
`endif
    endgenerate

`ifdef CLKDIV_READBACK_EN
    logic [CNT_W-1:0] r_rd_data;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_cnt_pad[bus.rd_sel];
        end
    end

    assign bus.rd_data = r_rd_data;
`endif

    assign bus.en_out  = w_en;
    assign bus.tog_out = w_tog;
endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed self-checking bench for clock_enable_gen (default 4-channel configuration).
module tb_clock_enable_gen;
    logic clk;
    logic clr;
    int   n_assert;
    int   n_fail;
    int   n;

    clock_enable_gen_if #(.N_CH(4), .CNT_W(32), .SEL_W(4)) bus ();

    clock_enable_gen dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until en_out[ch] is seen high; returns the tick count, or -1 if the bound expires.
    task automatic wait_en(input int ch, output int cnt);
        cnt = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (bus.en_out[ch] === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic wr(input logic [3:0] sel, input logic [31:0] data);
        bus.div_wr   = 1'b1;
        bus.div_sel  = sel;
        bus.div_data = data;
    endtask

    task automatic idle();
        bus.div_wr = 1'b0;
        bus.sync   = 1'b0;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        clr          = 1'b1;
        bus.sync     = 1'b0;
        bus.div_wr   = 1'b0;
        bus.div_sel  = '0;
        bus.div_data = '0;
`ifdef CLKDIV_READBACK_EN
        bus.rd_sel   = '0;
`endif
        // Reset state
        tick(); tick(); tick();
        chk("rst_en", 32'(bus.en_out), 32'h0);
        chk("rst_tog", 32'(bus.tog_out), 32'h0);

        // Reset defaults: ch0 divides by 4
        clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("def_en0", 32'(bus.en_out[0]), 32'(k % 4 == 0));
            chk("def_tog0", 32'(bus.tog_out[0]), 32'((k / 4) % 2));
        end
        chk("def_en_hi", 32'(bus.en_out[3:1]), 32'h0);

        // Mid-period write: current period finishes with 4, then 10
        tick();
        wr(4'd0, 32'd10);
        tick();
        idle();
        wait_en(0, n); chk("wr_mid_gap0", 32'(n), 32'd2);
        wait_en(0, n); chk("wr_mid_gap1", 32'(n), 32'd10);
        wait_en(0, n); chk("wr_mid_gap2", 32'(n), 32'd10);

        // Write on the wrap cycle: next gap already uses the new divisor
        for (int k = 1; k <= 9; k++) tick();
        chk("wrap_pre_en0", 32'(bus.en_out[0]), 32'd0);
        wr(4'd0, 32'd5);
        tick();
        idle();
        chk("wrap_en0", 32'(bus.en_out[0]), 32'd1);
        wait_en(0, n); chk("wrap_gap0", 32'(n), 32'd5);
        wait_en(0, n); chk("wrap_gap1", 32'(n), 32'd5);

        // Halt and restart ch1
        bus.sync = 1'b1;
        wr(4'd1, 32'd2);
        tick();
        idle();
        chk("sync_en", 32'(bus.en_out), 32'h0);
        chk("sync_tog", 32'(bus.tog_out), 32'h0);
        tick();
        chk("halt_pre_en1", 32'(bus.en_out[1]), 32'd0);
        wr(4'd1, 32'd0);
        tick();
        idle();
        chk("halt_last_en1", 32'(bus.en_out[1]), 32'd1);
        chk("halt_last_tog1", 32'(bus.tog_out[1]), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("halt_en1", 32'(bus.en_out[1]), 32'd0);
            chk("halt_tog1", 32'(bus.tog_out[1]), 32'd1);
        end
        wr(4'd1, 32'd3);
        tick();
        idle();
        wait_en(1, n); chk("restart_gap0", 32'(n), 32'd3);
        chk("restart_tog1", 32'(bus.tog_out[1]), 32'd0);
        wait_en(1, n); chk("restart_gap1", 32'(n), 32'd3);

        // Sync with ch0=4, ch1=6: pulses coincide every 12 cycles
        wr(4'd1, 32'd6);
        tick();
        wr(4'd0, 32'd4);
        bus.sync = 1'b1;
        tick();
        idle();
        chk("sync2_en", 32'(bus.en_out), 32'h0);
        chk("sync2_tog", 32'(bus.tog_out), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("sync_en0", 32'(bus.en_out[0]), 32'(k % 4 == 0));
            chk("sync_en1", 32'(bus.en_out[1]), 32'(k % 6 == 0));
        end
        chk("sync_tog0_pre", 32'(bus.tog_out[0]), 32'd1);

        // Sync held high keeps channels in reset phase
        bus.sync = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("synchold_en0", 32'(bus.en_out[0]), 32'd0);
            chk("synchold_tog0", 32'(bus.tog_out[0]), 32'd0);
        end
        bus.sync = 1'b0;

        // Divide by 1: enable high every cycle after the first
        wr(4'd0, 32'd1);
        bus.sync = 1'b1;
        tick();
        idle();
        chk("div1_first_en0", 32'(bus.en_out[0]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("div1_en0", 32'(bus.en_out[0]), 32'd1);
            chk("div1_tog0", 32'(bus.tog_out[0]), 32'(k % 2));
        end

        // Out-of-range select changes nothing
        wr(4'd7, 32'd2);
        bus.sync = 1'b1;
        tick();
        idle();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("sel7_en0", 32'(bus.en_out[0]), 32'd1);
            chk("sel7_en1", 32'(bus.en_out[1]), 32'(k == 6));
        end

        // clr mid-period clears outputs immediately
        tick();
        chk("preclr_tog0", 32'(bus.tog_out[0]), 32'd1);
        #2 clr = 1'b1;
        #1;
        chk("clr_en", 32'(bus.en_out), 32'h0);
        chk("clr_tog", 32'(bus.tog_out), 32'h0);
        tick();
        clr = 1'b0;
        wait_en(0, n); chk("clr_first_gap", 32'(n), 32'd4);
        chk("clr_first_tog0", 32'(bus.tog_out[0]), 32'd1);

`ifdef CLKDIV_READBACK_EN
        clr = 1'b1;
        bus.rd_sel = 4'd0;
        tick();
        chk("rd_rst", bus.rd_data, 32'd0);
        clr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("rd_cnt0", bus.rd_data, 32'((k - 1) % 4));
        end
        bus.rd_sel = 4'd7;
        tick();
        chk("rd_sel7", bus.rd_data, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
